obj_border_detect: RTL and testbench
====================================

# obj_border_detect

Parametrised droplet-border detector: reads pixel words from the upstream camera FIFO, builds a per-line absolute sum, learns a background level over the first lines, then tracks object entry/exit with hysteresis. Emits start/end events (line index, object length) to the downstream resampler. It is the next generation of the single-configuration detector and generalises word width, line length, background depth and hysteresis counts.

## Interface
- PIX_W, 8: signed pixel width (two's complement)
- PIX_PER_WORD, 16: pixels per FIFO word
- WORDS_PER_LINE, 21: FIFO words per image line (≥2)
- BG_LINES, 8: background learning lines; power of two, 2..64
- ENTER_CNT, 3: consecutive above-threshold lines to declare entry (≥1)
- EXIT_CNT, 3: consecutive below-threshold lines to declare exit (≥1)
- SUM_W, 32: line-sum and threshold width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; low freezes all state, forces rdfifo=0
- rddata  in  PIX_W*PIX_PER_WORD  FIFO data, pixel 0 in LSBs
- rdempty  in  1  FIFO empty
- rdfifo  out  1  FIFO read strobe (combinational)
- thres  in  SUM_W  unsigned error threshold, sampled at each line evaluation
- bg_relearn  in  1  request background relearn (pulse)
- obj_start  out  1  one-cycle pulse: object entered
- obj_end  out  1  one-cycle pulse: object left
- obj_line  out  16  start line index (valid with obj_start, held)
- obj_len  out  16  object length in lines (valid with obj_end, held)
- line_cnt  out  16  lines completed since reset/relearn
- stateoutput  out  2  current state (debug)

## Operation
- States: BG_LEARN(0) → OUT_OBJ(1) ↔ IN_OBJ(2). Reset enters BG_LEARN.
- rdfifo = ce & ~rdempty. Word appears on rddata the cycle after rdfifo; captured then (rd_vld).
- Per word: add Σ|pixel| to line accumulator; |−2^(PIX_W−1)| = 2^(PIX_W−1) (no overflow, zero-extended to SUM_W). Accumulator wraps modulo 2^SUM_W.
- After WORDS_PER_LINE words: line_sum latched, accumulator restarts with next word, no read bubble.
- BG_LEARN: add line_sum into bg_total; after BG_LINES lines bg_avg = bg_total >> log2(BG_LINES), go OUT_OBJ.
- Evaluation: err = |line_sum − bg_avg| (signed SUM_W+1 difference); above = err > thres (strict).
- OUT_OBJ: above increments run counter, below clears it. Run reaching ENTER_CNT → IN_OBJ, obj_start, obj_line = index of first line of the run.
- IN_OBJ: below increments run counter, above clears it and records last-above line. Run reaching EXIT_CNT → OUT_OBJ, obj_end, obj_len = last_above − obj_line + 1, saturating at 16'hFFFF.
- line_cnt wraps at 2^16; obj_len uses modulo difference before saturation check, so wrap is transparent.
- bg_relearn: latched; applied at next line boundary: clears bg_total, run counters, line_cnt; enters BG_LEARN. Open object is discarded, no obj_end. Relearn during BG_LEARN restarts learning.
- Words arriving while in any state are always consumed; the partially accumulated line is never dropped by relearn.

## Timing
- Reset values: rdfifo 0 (combinational, ce/rdempty driven), obj_start 0, obj_end 0, obj_line 0, obj_len 0, line_cnt 0, stateoutput 0.
- Throughput: one word per cycle while ~rdempty & ce.
- Latency: rdfifo of last word of line at cycle t → captured t+1 → line_sum valid t+2 → state, line_cnt, pulses registered, visible t+3.
- ce low at any cycle: rd_vld word pending from previous strobe is held in its register until ce returns; no pulse is generated or lost.
- Simultaneous bg_relearn and line completion: completed line is evaluated in current state first, then relearn applies.
- Reset mid-line: partial line discarded; learning restarts.

## Configuration
- DETECT_SMOOTH_EN defined: line_sum replaced by moving average of the last 8 line sums (8-entry ring, sum >> 3); ring cleared on reset/relearn and first 7 lines average with zeros; adds no cycle latency (sum registered with line_sum).
- Undefined: raw line_sum used; ring logic absent.

## Structure
- Package detect_pkg: state encoding constants, clog2 helper, abs-sum-of-word function.
- Sub-module line_abs_sum: word absolute-sum and per-line accumulator with word counter, outputs line_sum and line_done pulse.

## Test plan
- BG learn: 8 lines of all pixels = −3, thres=0 → bg_avg = 1008, state 1 after line 8, line_cnt=8.
- Entry: bg as above, then lines of pixel = 10 (sum 3360) → obj_start 3 cycles after last word of line 11 (3rd above), obj_line=8.
- Exit/length: 5 above lines then 3 background lines → obj_end, obj_len=5; single below line inside object does not end it.
- Hysteresis reset: pattern above, above, below, above, above, above → obj_start once, obj_line = 4th line of pattern.
- Relearn mid-object: bg_relearn during IN_OBJ → no obj_end, state 0 at next line boundary, line_cnt=0.
- Stalls: random rdempty and ce gaps with -8'h80 pixels → sums match model (2048 per word), no lost/duplicate words, rdfifo never high when rdempty.

Source files
------------

// File: rtl/detect_pkg.sv
// Shared types and helpers for the droplet-border detector.
//   state_e       : detector state encoding (also driven on the debug state port)
//   clog2         : ceiling log2 for parameter arithmetic
//   word_abs_sum  : sum of |pixel| over one packed FIFO word of signed pixels
package detect_pkg;

    typedef enum logic [1:0] {
        StBgLearn = 2'd0,
        StOutObj  = 2'd1,
        StInObj   = 2'd2
    } state_e;

    // Upper bounds for the generic word helper; callers zero-extend into these.
    localparam int unsigned MAX_WORD_W = 1024;
    localparam int unsigned MAX_SUM_W  = 64;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) res = i + 1;
        end
        return res;
    endfunction

    // The most negative pixel yields 2^(pix_w-1): magnitude is taken in a wider
    // field, so it never overflows.
    function automatic logic [MAX_SUM_W-1:0] word_abs_sum(
        input logic [MAX_WORD_W-1:0] word,
        input int unsigned           pix_w,
        input int unsigned           n_pix
    );
        logic [MAX_SUM_W-1:0] sum;
        logic [MAX_SUM_W-1:0] pix;
        logic [MAX_SUM_W-1:0] mask;
        logic [MAX_SUM_W-1:0] sign_bit;
        sum      = '0;
        mask     = (64'd1 << pix_w) - 64'd1;
        sign_bit = 64'd1 << (pix_w - 1);
        for (int i = 0; i < int'(n_pix); i++) begin
            pix = MAX_SUM_W'(word >> (i * pix_w)) & mask;
            if ((pix & sign_bit) != '0) pix = (~pix + 64'd1) & mask;
            sum = sum + pix;
        end
        return sum;
    endfunction

endpackage

// File: rtl/line_abs_sum.sv
// Per-line absolute-sum accumulator.
// Adds sum(|pixel|) of every captured word into a line accumulator (modulo
// 2^SUM_W); on the last word of a line latches the total and pulses line_done
// for one enabled cycle. The next line starts with the following word.
// Optional: DETECT_SMOOTH_EN replaces the latched sum by the mean of the last
// eight line sums (ring cleared on reset and on i_clr).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_ce            clock enable, low freezes all state
//   i_vld           i_word holds a word to consume this cycle
//   i_word          packed signed pixels, pixel 0 in LSBs
//   i_clr           clear smoothing history (background relearn)
//   o_line_sum      latched line total
//   o_line_done     one-cycle pulse, o_line_sum is fresh
module line_abs_sum
    import detect_pkg::*;
#(
    parameter int unsigned PIX_W          = 8,
    parameter int unsigned PIX_PER_WORD   = 16,
    parameter int unsigned WORDS_PER_LINE = 21,
    parameter int unsigned SUM_W          = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ce,
    input  logic                          i_vld,
    input  logic [PIX_W*PIX_PER_WORD-1:0] i_word,
    input  logic                          i_clr,
    output logic [SUM_W-1:0]              o_line_sum,
    output logic                          o_line_done
);

    localparam int unsigned CNT_W = clog2(WORDS_PER_LINE);

    logic [MAX_WORD_W-1:0] w_word_ext;
    logic [SUM_W-1:0]      w_word_sum;
    logic [SUM_W-1:0]      w_acc_next;
    logic [SUM_W-1:0]      w_line_val;
    logic                  w_last;

    logic [SUM_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_word_cnt;
    logic [SUM_W-1:0]      r_line_sum;
    logic                  r_line_done;

    assign w_word_ext = MAX_WORD_W'(i_word);
    assign w_word_sum = SUM_W'(word_abs_sum(w_word_ext, PIX_W, PIX_PER_WORD));
    assign w_acc_next = r_acc + w_word_sum;
    assign w_last     = (r_word_cnt == CNT_W'(WORDS_PER_LINE - 1));

`ifdef DETECT_SMOOTH_EN
    localparam int unsigned RING_W = SUM_W + 3;

    logic [SUM_W-1:0]  r_ring [8];
    logic [2:0]        r_ring_idx;
    logic [RING_W-1:0] r_ring_sum;
    logic [RING_W-1:0] w_ring_sum_next;

    // Running total of the ring: drop the oldest entry, add the new line.
    assign w_ring_sum_next = r_ring_sum - RING_W'(r_ring[r_ring_idx]) + RING_W'(w_acc_next);
    assign w_line_val      = SUM_W'(w_ring_sum_next >> 3);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) r_ring[i] <= '0;
            r_ring_idx <= '0;
            r_ring_sum <= '0;
        end else if (i_ce) begin
            if (i_clr) begin
                for (int i = 0; i < 8; i++) r_ring[i] <= '0;
                r_ring_idx <= '0;
                r_ring_sum <= '0;
            end else if (i_vld && w_last) begin
                r_ring[r_ring_idx] <= w_acc_next;
                r_ring_idx         <= r_ring_idx + 3'd1;
                r_ring_sum         <= w_ring_sum_next;
            end
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr;
    assign w_line_val   = w_acc_next;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc       <= '0;
            r_word_cnt  <= '0;
            r_line_sum  <= '0;
            r_line_done <= 1'b0;
        end else if (i_ce) begin
            if (i_vld) begin
                if (w_last) begin
                    r_line_sum  <= w_line_val;
                    r_acc       <= '0;
                    r_word_cnt  <= '0;
                    r_line_done <= 1'b1;
                end else begin
                    r_acc       <= w_acc_next;
                    r_word_cnt  <= r_word_cnt + 1'b1;
                    r_line_done <= 1'b0;
                end
            end else begin
                r_line_done <= 1'b0;
            end
        end
    end

    assign o_line_sum  = r_line_sum;
    assign o_line_done = r_line_done;

endmodule

// File: rtl/obj_border_detect.sv
// Droplet-border detector top level.
// Reads pixel words from the camera FIFO, learns a background line level over
// BG_LINES lines, then tracks object entry/exit with ENTER_CNT/EXIT_CNT line
// hysteresis and reports start line and object length.
// Optional: DETECT_SMOOTH_EN (in line_abs_sum) smooths line sums over 8 lines.
// Ports:
//   i_clk, i_reset     clock, asynchronous active-low reset
//   i_ce               clock enable; low freezes state and blocks FIFO reads
//   i_rddata           FIFO word (valid the cycle after o_rdfifo)
//   i_rdempty          FIFO empty
//   o_rdfifo           FIFO read strobe, combinational
//   i_thres            unsigned error threshold, sampled per line evaluation
//   i_bg_relearn       background relearn request, applied at next line end
//   o_obj_start/end    one-cycle event pulses
//   o_obj_line         first line of object (held)
//   o_obj_len          object length in lines, saturating (held)
//   o_line_cnt         lines completed since reset/relearn
//   o_stateoutput      current state (debug)
module obj_border_detect
    import detect_pkg::*;
#(
    parameter int unsigned PIX_W          = 8,
    parameter int unsigned PIX_PER_WORD   = 16,
    parameter int unsigned WORDS_PER_LINE = 21,
    parameter int unsigned BG_LINES       = 8,
    parameter int unsigned ENTER_CNT      = 3,
    parameter int unsigned EXIT_CNT       = 3,
    parameter int unsigned SUM_W          = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_ce,
    input  logic [PIX_W*PIX_PER_WORD-1:0] i_rddata,
    input  logic                          i_rdempty,
    output logic                          o_rdfifo,
    input  logic [SUM_W-1:0]              i_thres,
    input  logic                          i_bg_relearn,
    output logic                          o_obj_start,
    output logic                          o_obj_end,
    output logic [15:0]                   o_obj_line,
    output logic [15:0]                   o_obj_len,
    output logic [15:0]                   o_line_cnt,
    output logic [1:0]                    o_stateoutput
);

    localparam int unsigned BG_SHIFT = clog2(BG_LINES);
    localparam int unsigned BG_W     = SUM_W + BG_SHIFT;

    state_e           r_state;
    logic             r_rd_vld;
    logic             r_relearn_pend;
    logic [BG_W-1:0]  r_bg_total;
    logic [SUM_W-1:0] r_bg_avg;
    logic [15:0]      r_run;
    logic [15:0]      r_line_cnt;
    logic [15:0]      r_obj_line;
    logic [15:0]      r_obj_len;
    logic [15:0]      r_last_above;
    logic             r_obj_start;
    logic             r_obj_end;

    logic             w_line_done;
    logic [SUM_W-1:0] w_line_sum;
    logic             w_relearn_apply;
    logic [SUM_W:0]   w_diff;
    logic [SUM_W-1:0] w_err;
    logic             w_above;
    logic [BG_W-1:0]  w_bg_next;
    logic [15:0]      w_run_inc;
    logic [15:0]      w_len_diff;
    logic [16:0]      w_len;

    assign o_rdfifo = i_ce & ~i_rdempty;

    // A pending word stays pending across ce-low cycles; the FIFO output holds
    // because no further strobe is issued meanwhile.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_vld <= 1'b0;
        end else if (i_ce) begin
            r_rd_vld <= o_rdfifo;
        end
    end

    line_abs_sum #(
        .PIX_W          (PIX_W),
        .PIX_PER_WORD   (PIX_PER_WORD),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .SUM_W          (SUM_W)
    ) u_line_abs_sum (
        .i_clk       (i_clk),
        .i_rst_n     (i_reset),
        .i_ce        (i_ce),
        .i_vld       (r_rd_vld),
        .i_word      (i_rddata),
        .i_clr       (w_relearn_apply),
        .o_line_sum  (w_line_sum),
        .o_line_done (w_line_done)
    );

    // A request arriving on the boundary cycle itself also applies there.
    assign w_relearn_apply = i_ce & w_line_done & (r_relearn_pend | i_bg_relearn);

    assign w_diff     = {1'b0, w_line_sum} - {1'b0, r_bg_avg};
    assign w_err      = w_diff[SUM_W] ? SUM_W'(-w_diff) : w_diff[SUM_W-1:0];
    assign w_above    = (w_err > i_thres);
    assign w_bg_next  = r_bg_total + BG_W'(w_line_sum);
    assign w_run_inc  = r_run + 16'd1;
    // Modulo difference first so a line counter wrap inside an object is harmless.
    assign w_len_diff = r_last_above - r_obj_line;
    assign w_len      = {1'b0, w_len_diff} + 17'd1;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= StBgLearn;
            r_relearn_pend <= 1'b0;
            r_bg_total     <= '0;
            r_bg_avg       <= '0;
            r_run          <= '0;
            r_line_cnt     <= '0;
            r_obj_line     <= '0;
            r_obj_len      <= '0;
            r_last_above   <= '0;
            r_obj_start    <= 1'b0;
            r_obj_end      <= 1'b0;
        end else if (i_ce) begin
            r_obj_start <= 1'b0;
            r_obj_end   <= 1'b0;
            if (w_relearn_apply) begin
                r_relearn_pend <= 1'b0;
            end else if (i_bg_relearn) begin
                r_relearn_pend <= 1'b1;
            end

            if (w_line_done) begin
                r_line_cnt <= r_line_cnt + 16'd1;
                unique case (r_state)
                    StBgLearn: begin
                        if (r_line_cnt == 16'(BG_LINES - 1)) begin
                            r_bg_avg <= SUM_W'(w_bg_next >> BG_SHIFT);
                            r_state  <= StOutObj;
                            r_run    <= '0;
                        end else begin
                            r_bg_total <= w_bg_next;
                        end
                    end
                    StOutObj: begin
                        if (w_above) begin
                            if (w_run_inc == 16'(ENTER_CNT)) begin
                                r_state      <= StInObj;
                                r_obj_start  <= 1'b1;
                                r_obj_line   <= r_line_cnt - 16'(ENTER_CNT - 1);
                                r_last_above <= r_line_cnt;
                                r_run        <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                    StInObj: begin
                        if (!w_above) begin
                            if (w_run_inc == 16'(EXIT_CNT)) begin
                                r_state   <= StOutObj;
                                r_obj_end <= 1'b1;
                                r_obj_len <= w_len[16] ? 16'hFFFF : w_len[15:0];
                                r_run     <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_run        <= '0;
                            r_last_above <= r_line_cnt;
                        end
                    end
                    default: r_state <= StBgLearn;
                endcase

                // Evaluated line above keeps its outcome; relearn then overrides state.
                if (w_relearn_apply) begin
                    r_state    <= StBgLearn;
                    r_bg_total <= '0;
                    r_run      <= '0;
                    r_line_cnt <= '0;
                end
            end
        end
    end

    assign o_obj_start   = r_obj_start;
    assign o_obj_end     = r_obj_end;
    assign o_obj_line    = r_obj_line;
    assign o_obj_len     = r_obj_len;
    assign o_line_cnt    = r_line_cnt;
    assign o_stateoutput = r_state;

endmodule

// File: tb/tb_obj_border_detect.sv
// Scoreboard bench for obj_border_detect: each issued line pushes its expected
// per-line outcome; a monitor pops and compares whenever a line is evaluated.
module tb_obj_border_detect;

    localparam int PIX_W  = 8;
    localparam int PPW    = 16;
    localparam int WPL    = 21;
    localparam int SUM_W  = 32;
    localparam int WORD_W = PIX_W * PPW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b0;
    logic              rdempty = 1'b1;
    logic              bg_relearn = 1'b0;
    logic [WORD_W-1:0] rddata = '0;
    logic [SUM_W-1:0]  thres = '0;
    logic              rdfifo;
    logic              obj_start;
    logic              obj_end;
    logic [15:0]       obj_line;
    logic [15:0]       obj_len;
    logic [15:0]       line_cnt;
    logic [1:0]        stateoutput;

    obj_border_detect dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_ce          (ce),
        .i_rddata      (rddata),
        .i_rdempty     (rdempty),
        .o_rdfifo      (rdfifo),
        .i_thres       (thres),
        .i_bg_relearn  (bg_relearn),
        .o_obj_start   (obj_start),
        .o_obj_end     (obj_end),
        .o_obj_line    (obj_line),
        .o_obj_len     (obj_len),
        .o_line_cnt    (line_cnt),
        .o_stateoutput (stateoutput)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic [1:0]  state;
        logic [15:0] cnt;
        logic        start;
        logic [15:0] sline;
        logic        fin;
        logic [15:0] len;
    } exp_t;

    exp_t              exp_q[$];
    logic [WORD_W-1:0] fifo_q[$];
    int                n_pass = 0;
    int                n_total = 0;
    int                viol = 0;
    int                underflow = 0;
    bit                stall_mode = 1'b0;
    bit                drv_en = 1'b0;
    bit                mon_en = 1'b0;
    bit                eval_pend = 1'b0;
    logic [31:0]       cap_sum = '0;
    exp_t              e_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    function automatic exp_t mk(input int sum, input int st, input int cnt, input bit start,
                                input int sline, input bit fin, input int len);
        exp_t e;
        e.sum   = 32'(sum);
        e.state = 2'(st);
        e.cnt   = 16'(cnt);
        e.start = start;
        e.sline = 16'(sline);
        e.fin   = fin;
        e.len   = 16'(len);
        return e;
    endfunction

    // Even pixels take pa, odd pixels pb.
    task automatic send_line(input logic [7:0] pa, input logic [7:0] pb, input exp_t e);
        logic [WORD_W-1:0] w;
        for (int p = 0; p < PPW; p++) w[p*PIX_W +: PIX_W] = p[0] ? pb : pa;
        for (int k = 0; k < WPL; k++) fifo_q.push_back(w);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20000; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, 32'(exp_q.size() + fifo_q.size()), 32'd0);
    endtask

    // FIFO model: word presented the cycle after the strobe, held otherwise.
    always @(posedge clk) begin
        if (rdfifo) begin
            if (fifo_q.size() > 0) rddata <= fifo_q.pop_front();
            else underflow++;
        end
    end

    always @(negedge clk) begin
        if (drv_en) begin
            ce      = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdempty = (fifo_q.size() == 0) || (stall_mode && $urandom_range(0, 2) == 0);
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (rdfifo && rdempty) viol++;
            if (eval_pend) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_line", 32'd1, 32'd0);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("line_sum", cap_sum, e_cur.sum);
                    chk("state", 32'(stateoutput), 32'(e_cur.state));
                    chk("line_cnt", 32'(line_cnt), 32'(e_cur.cnt));
                    chk("obj_start", 32'(obj_start), 32'(e_cur.start));
                    if (e_cur.start) chk("obj_line", 32'(obj_line), 32'(e_cur.sline));
                    chk("obj_end", 32'(obj_end), 32'(e_cur.fin));
                    if (e_cur.fin) chk("obj_len", 32'(obj_len), 32'(e_cur.len));
                end
            end
            eval_pend = ce && dut.w_line_done;
            cap_sum   = dut.w_line_sum;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] neg3;
        logic [7:0] pos10;
        neg3  = 8'hFD;
        pos10 = 8'h0A;

        // Reset state and combinational read strobe.
        rst_n = 1'b0; ce = 1'b0; rdempty = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdfifo_ce_low", 32'(rdfifo), 32'd0);
        ce = 1'b1; #1;
        chk("rdfifo_ce_notempty", 32'(rdfifo), 32'd1);
        rdempty = 1'b1; #1;
        chk("rdfifo_empty", 32'(rdfifo), 32'd0);
        chk("rst_obj_start", 32'(obj_start), 32'd0);
        chk("rst_obj_end", 32'(obj_end), 32'd0);
        chk("rst_obj_line", 32'(obj_line), 32'd0);
        chk("rst_obj_len", 32'(obj_len), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        chk("rst_state", 32'(stateoutput), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        drv_en = 1'b1;
        mon_en = 1'b1;
        thres  = '0;

        // Background: 16 px * 3 * 21 words = 1008 per line.
        for (int i = 0; i < 8; i++) send_line(neg3, neg3, mk(1008, (i == 7) ? 1 : 0, i + 1, 0, 0, 0, 0));

        // Object 1: lines 8..12 above (3360), 13..15 background.
        send_line(pos10, pos10, mk(3360, 1, 9, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 1, 10, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 2, 11, 1, 8, 0, 0));
        send_line(pos10, pos10, mk(3360, 2, 12, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 2, 13, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 2, 14, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 2, 15, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 1, 16, 0, 0, 1, 5));

        // Hysteresis: A A B A A A -> start on line 21, first line 19.
        send_line(pos10, pos10, mk(3360, 1, 17, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 1, 18, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 1, 19, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 1, 20, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 1, 21, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 2, 22, 1, 19, 0, 0));
        // Single below lines inside the object must not close it.
        send_line(neg3, neg3, mk(1008, 2, 23, 0, 0, 0, 0));
        send_line(pos10, pos10, mk(3360, 2, 24, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 2, 25, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 2, 26, 0, 0, 0, 0));
        wait_drain("drain_objects");

        // Relearn mid-line inside an object: no obj_end, back to learning.
        send_line(pos10, pos10, mk(3360, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 500; i++) begin
            if (fifo_q.size() <= 10) break;
            @(negedge clk);
        end
        @(negedge clk);
        bg_relearn = 1'b1;
        @(negedge clk);
        bg_relearn = 1'b0;
        wait_drain("drain_relearn");

        // Stalls with most-negative pixels: 16 * 128 = 2048 per word, 43008 per line.
        stall_mode = 1'b1;
        for (int i = 0; i < 8; i++) send_line(8'h80, 8'h80, mk(43008, (i == 7) ? 1 : 0, i + 1, 0, 0, 0, 0));
        // -128/+127 alternating: 8 * 255 * 21 = 42840, differs from background.
        send_line(8'h80, 8'h7F, mk(42840, 1, 9, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 1, 10, 0, 0, 0, 0));
        send_line(neg3, neg3, mk(1008, 2, 11, 1, 8, 0, 0));
        wait_drain("drain_stalls");
        stall_mode = 1'b0;
        repeat (4) @(negedge clk);

        chk("rdfifo_while_empty", 32'(viol), 32'd0);
        chk("fifo_underflow", 32'(underflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
